dfr_argmax_classifier: RTL and testbench

- Downstream consumer of the matrix-multiply stage. Once the product matrix Z (z_rows x z_cols, row-major, signed 32-bit) has been written to Z RAM, this block scans it row by row.
- For each row it finds the column index of the maximum value and writes that index to a class RAM, one word per row.
- This produces the DFR classifier's predicted label per sample.

---
 rtl/dfr_pkg.sv | 16 +
 rtl/dfr_argmax_cmp_unit.sv | 54 +++++
 rtl/dfr_argmax_classifier.sv | 178 +++++++++++++++++
 tb/tb_dfr_argmax_classifier.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/dfr_pkg.sv
// Shared types and defaults for the DFR classifier datapath.
// ARGMAX_MAXVAL_EN adds the max_data output to dfr_argmax_classifier.
package dfr_pkg;
  localparam int RAM_RD_LATENCY = 1;
  localparam int DFR_ADDR_WIDTH = 32;
  localparam int DFR_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    ROW_INIT,
    STREAM,
    DRAIN,
    WRITE,
    DONE
  } argmax_state_t;
endpackage

// File: rtl/dfr_argmax_cmp_unit.sv
// Running signed maximum and its index over one Z row.
// max/idx show the result including the datum presented this cycle.
module argmax_cmp_unit
  import dfr_pkg::*;
#(
  parameter int DATA_WIDTH = DFR_DATA_WIDTH,
  parameter int ADDR_WIDTH = DFR_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ADDR_WIDTH-1:0] index,
  output logic [DATA_WIDTH-1:0] max,
  output logic [ADDR_WIDTH-1:0] idx
);
  logic                  has_q, has_d;
  logic [DATA_WIDTH-1:0] max_q, max_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;

  always_comb begin
    has_d = has_q;
    max_d = max_q;
    idx_d = idx_q;
    if (clear) begin
      has_d = 1'b0;
      max_d = '0;
      idx_d = '0;
    end else if (valid) begin
      // strict compare keeps the lowest index on ties
      if (!has_q || ($signed(data) > $signed(max_q))) begin
        has_d = 1'b1;
        max_d = data;
        idx_d = index;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      has_q <= 1'b0;
      max_q <= '0;
      idx_q <= '0;
    end else begin
      has_q <= has_d;
      max_q <= max_d;
      idx_q <= idx_d;
    end
  end

  assign max = max_d;
  assign idx = idx_d;
endmodule

// File: rtl/dfr_argmax_classifier.sv
// Row-wise argmax over the Z product matrix, one class word per row.
// Define ARGMAX_MAXVAL_EN to expose the winning value on max_data.
module dfr_argmax_classifier
  import dfr_pkg::*;
#(
  parameter int ADDR_WIDTH = DFR_ADDR_WIDTH,
  parameter int DATA_WIDTH = DFR_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] z_rows,
  input  logic [ADDR_WIDTH-1:0] z_cols,
  input  logic [DATA_WIDTH-1:0] z_data,
  output logic [ADDR_WIDTH-1:0] z_addr,
  output logic [ADDR_WIDTH-1:0] class_addr,
  output logic [ADDR_WIDTH-1:0] class_data,
  output logic                  class_wen,
`ifdef ARGMAX_MAXVAL_EN
  output logic [DATA_WIDTH-1:0] max_data,
`endif
  output logic                  busy,
  output logic                  done
);
  argmax_state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] rows_q, rows_d;
  logic [ADDR_WIDTH-1:0] cols_q, cols_d;
  logic [ADDR_WIDTH-1:0] row_q, row_d;
  logic [ADDR_WIDTH-1:0] col_q, col_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] z_addr_q, z_addr_d;
  logic [ADDR_WIDTH-1:0] class_addr_q, class_addr_d;
  logic [ADDR_WIDTH-1:0] class_data_q, class_data_d;
  logic                  class_wen_q, class_wen_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  vld_q, vld_d;
  logic [ADDR_WIDTH-1:0] cidx_q, cidx_d;
  logic [DATA_WIDTH-1:0] max_data_q, max_data_d;

  logic                  cmp_clear;
  logic [DATA_WIDTH-1:0] cmp_max;
  logic [ADDR_WIDTH-1:0] cmp_idx;

  assign cmp_clear = (state_q == ROW_INIT);

  argmax_cmp_unit #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_cmp (
    .clk  (clk),
    .rst  (rst),
    .clear(cmp_clear),
    .valid(vld_q),
    .data (z_data),
    .index(cidx_q),
    .max  (cmp_max),
    .idx  (cmp_idx)
  );

  always_comb begin
    state_d      = state_q;
    rows_d       = rows_q;
    cols_d       = cols_q;
    row_d        = row_q;
    col_d        = col_q;
    base_d       = base_q;
    z_addr_d     = z_addr_q;
    class_addr_d = class_addr_q;
    class_data_d = class_data_q;
    class_wen_d  = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    max_data_d   = max_data_q;
    // tags each issued address so the returning datum knows its column
    vld_d        = (state_q == STREAM);
    cidx_d       = col_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          rows_d   = z_rows;
          cols_d   = z_cols;
          row_d    = '0;
          col_d    = '0;
          base_d   = '0;
          z_addr_d = '0;
          busy_d   = 1'b1;
          state_d  = ROW_INIT;
        end
      end
      ROW_INIT: begin
        if (row_q == rows_q || cols_q == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end else begin
          z_addr_d = base_q;
          col_d    = '0;
          state_d  = STREAM;
        end
      end
      STREAM: begin
        if (col_q < cols_q - ADDR_WIDTH'(1)) begin
          z_addr_d = z_addr_q + ADDR_WIDTH'(1);
          col_d    = col_q + ADDR_WIDTH'(1);
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        class_wen_d  = 1'b1;
        class_addr_d = row_q;
        class_data_d = cmp_idx;
        max_data_d   = cmp_max;
        state_d      = WRITE;
      end
      WRITE: begin
        base_d  = base_q + cols_q;
        row_d   = row_q + ADDR_WIDTH'(1);
        state_d = ROW_INIT;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rows_q       <= '0;
      cols_q       <= '0;
      row_q        <= '0;
      col_q        <= '0;
      base_q       <= '0;
      z_addr_q     <= '0;
      class_addr_q <= '0;
      class_data_q <= '0;
      class_wen_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      vld_q        <= 1'b0;
      cidx_q       <= '0;
      max_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      rows_q       <= rows_d;
      cols_q       <= cols_d;
      row_q        <= row_d;
      col_q        <= col_d;
      base_q       <= base_d;
      z_addr_q     <= z_addr_d;
      class_addr_q <= class_addr_d;
      class_data_q <= class_data_d;
      class_wen_q  <= class_wen_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      vld_q        <= vld_d;
      cidx_q       <= cidx_d;
      max_data_q   <= max_data_d;
    end
  end

  assign z_addr     = z_addr_q;
  assign class_addr = class_addr_q;
  assign class_data = class_data_q;
  assign class_wen  = class_wen_q;
  assign busy       = busy_q;
  assign done       = done_q;
`ifdef ARGMAX_MAXVAL_EN
  assign max_data   = max_data_q;
`else
  logic unused_max;
  assign unused_max = ^max_data_q;
`endif
endmodule

// File: tb/tb_dfr_argmax_classifier.sv
// Self-checking bench for dfr_argmax_classifier against a plain argmax model.
// Honors ARGMAX_MAXVAL_EN for the optional max_data output.
module tb_dfr_argmax_classifier;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] z_rows, z_cols, z_data;
  logic [31:0] z_addr, class_addr, class_data;
  logic        class_wen, busy, done;
`ifdef ARGMAX_MAXVAL_EN
  logic [31:0] max_data;
`endif

  int checks = 0;
  int failures = 0;
  logic [31:0] mem [64];

  always #5 clk = ~clk;

  always @(posedge clk) z_data <= mem[z_addr[5:0]];

  dfr_argmax_classifier dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .z_rows    (z_rows),
    .z_cols    (z_cols),
    .z_data    (z_data),
    .z_addr    (z_addr),
    .class_addr(class_addr),
    .class_data(class_data),
    .class_wen (class_wen),
`ifdef ARGMAX_MAXVAL_EN
    .max_data  (max_data),
`endif
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_z_addr"}, z_addr, 0);
    chk({tag, "_class_addr"}, class_addr, 0);
    chk({tag, "_class_data"}, class_data, 0);
    chk({tag, "_class_wen"}, {31'd0, class_wen}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
`ifdef ARGMAX_MAXVAL_EN
    chk({tag, "_max_data"}, max_data, 0);
`endif
  endtask

  task automatic run_scan(input string tag, input int r, input int c,
                          input bit repulse, input int abort_at);
    int exp_idx[$];
    logic [31:0] exp_max[$];
    int w_addr[$];
    int w_data[$];
    logic [31:0] w_max[$];
    int seq[$];
    int first_wen = -1;
    int done_cyc = -1;
    int ndone = 0;
    int budget;
    int exp_done;
    for (int i = 0; i < r && c > 0; i++) begin
      int best = 0;
      for (int j = 1; j < c; j++)
        if ($signed(mem[i*c+j]) > $signed(mem[i*c+best]))
          best = j;
      exp_idx.push_back(best);
      exp_max.push_back(mem[i*c+best]);
    end
    exp_done = (r == 0 || c == 0) ? 2 : r * (c + 3) + 2;
    budget = exp_done + 20;
    @(negedge clk);
    z_rows = r;
    z_cols = c;
    start = 1'b1;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 1) begin
        z_rows = $urandom;
        z_cols = $urandom;
        chk({tag, "_busy_early"}, {31'd0, busy}, 1);
      end
      start = repulse && (cyc == 3 || cyc == 5);
      if (cyc == abort_at) begin
        rst = 1'b1;
        #1;
        chk_outs_zero({tag, "_abort"});
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (seq.size() == 0 || seq[$] != int'(z_addr))
        seq.push_back(int'(z_addr));
      if (class_wen) begin
        if (first_wen < 0) first_wen = cyc;
        w_addr.push_back(int'(class_addr));
        w_data.push_back(int'(class_data));
`ifdef ARGMAX_MAXVAL_EN
        w_max.push_back(max_data);
`else
        w_max.push_back(32'd0);
`endif
      end
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc > 0 && cyc >= done_cyc + 3) break;
    end
    chk({tag, "_ndone"}, ndone, 1);
    chk({tag, "_done_cyc"}, done_cyc, exp_done);
    chk({tag, "_busy_after"}, {31'd0, busy}, 0);
    chk({tag, "_nwrites"}, w_addr.size(), exp_idx.size());
    for (int i = 0; i < w_addr.size() && i < exp_idx.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), w_addr[i], i);
      chk($sformatf("%s_class%0d", tag, i), w_data[i], exp_idx[i]);
`ifdef ARGMAX_MAXVAL_EN
      chk($sformatf("%s_max%0d", tag, i), w_max[i], exp_max[i]);
`endif
    end
    if (r > 0 && c > 0) begin
      chk({tag, "_first_wen"}, first_wen, c + 3);
      chk({tag, "_seq_len"}, seq.size(), r * c);
      for (int i = 0; i < seq.size(); i++)
        chk($sformatf("%s_zaddr%0d", tag, i), seq[i], i);
    end
  endtask

  task automatic load(input int n, input int mode);
    for (int i = 0; i < n; i++)
      mem[i] = (mode == 0) ? $urandom
                           : 32'($signed($urandom_range(0, 3)) - 1);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    z_rows = 0;
    z_cols = 0;
    for (int i = 0; i < 64; i++) mem[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_outs_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    mem[0] = 5; mem[1] = -3; mem[2] = 9; mem[3] = 2;
    run_scan("r1x4", 1, 4, 0, 0);

    mem[0] = 1;  mem[1] = 2;  mem[2] = 3;
    mem[3] = 7;  mem[4] = 7;  mem[5] = 1;
    mem[6] = -5; mem[7] = -1; mem[8] = -9;
    run_scan("r3x3", 3, 3, 0, 0);

    run_scan("rows0", 0, 3, 0, 0);
    run_scan("cols0", 2, 0, 0, 0);

    mem[0] = 32'h8000_0000; mem[1] = 32'h7FFF_FFFF; mem[2] = 0;
    run_scan("extreme", 1, 3, 0, 0);

    mem[0] = 4; mem[1] = -8; mem[2] = 32'h8000_0000;
    run_scan("cols1", 3, 1, 0, 0);

    load(10, 0);
    run_scan("repulse", 2, 5, 1, 0);

    load(16, 0);
    run_scan("abort", 4, 4, 0, 12);
    load(16, 1);
    run_scan("post_abort", 4, 4, 0, 0);

    for (int t = 0; t < 8; t++) begin
      int r = $urandom_range(1, 4);
      int c = $urandom_range(1, 8);
      load(r * c, t % 2);
      run_scan($sformatf("rand%0d", t), r, c, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
